iob_ram_responder: RTL and testbench

IOb native-bus responder backed by an internal word-addressed RAM. It answers the request/response interface that the CPU wrapper issues on its instruction and data buses. It supports a programmable read latency, write wait-states and `ready` backpressure, and serves as the memory endpoint for simulation and for small on-chip program/data memories. Reads return one `rvalid` pulse per accepted read; writes are acknowledged only by acceptance.

---
 rtl/iob_ram_responder.sv | 97 +++++++++
 tb/tb_iob_ram_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/iob_ram_responder.sv
// iob_ram_responder: IOb native-bus responder over an internal byte-writable word RAM
// with programmable read latency and write wait-states.
module iob_ram_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int READ_LAT   = 1,
  parameter int WRITE_WAIT = 0
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_ready_o
);
  typedef enum logic [1:0] {IDLE, RWAIT, WWAIT} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d, idx;
  logic rvalid_q, rvalid_d, ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  logic acc, rd, wr;
  logic unused_addr;
  assign unused_addr = ^{iob_addr_i[1:0], iob_addr_i[ADDR_W-1:MEM_ADDR_W+2]};
  assign idx = iob_addr_i[MEM_ADDR_W+1:2];
  assign acc = iob_avalid_i & ready_q & cke_i;
  assign wr  = acc & |iob_wstrb_i;
  assign rd  = acc & ~|iob_wstrb_i;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd && READ_LAT == 1) begin
          rdata_d  = mem[idx];
          rvalid_d = 1'b1;
        end else if (rd) begin
          state_d = RWAIT;
          cnt_d   = 5'(READ_LAT - 1);
          addr_d  = idx;
        end else if (wr && WRITE_WAIT > 0) begin
          state_d = WWAIT;
          cnt_d   = 5'(WRITE_WAIT);
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          rdata_d  = mem[addr_q];
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      WWAIT: begin
        cnt_d   = cnt_q - 5'd1;
        state_d = cnt_q == 5'd1 ? IDLE : WWAIT;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b1;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
    end
  end
  // RAM contents survive reset; only a write accepted outside reset lands
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr)
      for (int i = 0; i < DATA_W/8; i++)
        if (iob_wstrb_i[i]) mem[idx][8*i +: 8] <= iob_wdata_i[8*i +: 8];
  end
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;
  assign iob_ready_o  = ready_q;
endmodule

// File: tb/tb_iob_ram_responder.sv
// tb_iob_ram_responder: directed vectors plus randomized traffic on two configurations
// (u0: READ_LAT=1, u1: READ_LAT=4/WRITE_WAIT=2/MEM_ADDR_W=4) against a cycle-count model.
module tb_iob_ram_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic av[2], ck[2], rs[2], rv[2], rdy[2];
  logic [31:0] ad[2], wd[2], rdt[2];
  logic [3:0] ws[2];
  iob_ram_responder #(.READ_LAT(1)) u0 (
    .clk_i(clk), .cke_i(ck[0]), .rst_i(rs[0]), .iob_avalid_i(av[0]), .iob_addr_i(ad[0]),
    .iob_wdata_i(wd[0]), .iob_wstrb_i(ws[0]), .iob_rvalid_o(rv[0]), .iob_rdata_o(rdt[0]),
    .iob_ready_o(rdy[0]));
  iob_ram_responder #(.MEM_ADDR_W(4), .READ_LAT(4), .WRITE_WAIT(2)) u1 (
    .clk_i(clk), .cke_i(ck[1]), .rst_i(rs[1]), .iob_avalid_i(av[1]), .iob_addr_i(ad[1]),
    .iob_wdata_i(wd[1]), .iob_wstrb_i(ws[1]), .iob_rvalid_o(rv[1]), .iob_rdata_o(rdt[1]),
    .iob_ready_o(rdy[1]));
  int total = 0, bad = 0;
  typedef struct {
    logic av; logic [31:0] addr; logic [31:0] wd; logic [3:0] ws;
    logic rdy; logic rv; logic [31:0] rd;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic drive(input int i, input logic a, input logic [31:0] adr, input logic [31:0] d,
                       input logic [3:0] s, input logic c, input logic r);
    av[i] = a; ad[i] = adr; wd[i] = d; ws[i] = s; ck[i] = c; rs[i] = r;
    @(negedge clk);
  endtask
  function automatic int lat(input int i); return i == 1 ? 4 : 1; endfunction
  function automatic int ww(input int i); return i == 1 ? 2 : 0; endfunction
  function automatic int maw(input int i); return i == 1 ? 4 : 10; endfunction
  function automatic logic [31:0] bmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction
  // Model: time counts only enabled edges since reset; a request accepted at count E
  // makes the bus busy until E+READ_LAT (read) or E+1+WRITE_WAIT (write).
  logic [31:0] m_mem[2][1024];
  logic [3:0] m_known[2][1024];
  int m_e[2], m_busy[2], m_due[2];
  logic [31:0] m_pd[2], m_pm[2], m_rd[2], m_rm[2];
  task automatic model(input int i);
    int w;
    if (rs[i]) begin
      m_e[i] = 0; m_busy[i] = 0; m_due[i] = -1; m_rd[i] = '0; m_rm[i] = '1;
    end else if (ck[i]) begin
      if (av[i] && m_e[i] >= m_busy[i]) begin
        w = int'(ad[i][11:2]) & ((1 << maw(i)) - 1);
        if (ws[i] == 4'h0) begin
          m_due[i] = m_e[i] + lat(i);
          m_busy[i] = m_due[i];
          m_pd[i] = m_mem[i][w];
          m_pm[i] = bmask(m_known[i][w]);
        end else begin
          for (int b = 0; b < 4; b++)
            if (ws[i][b]) m_mem[i][w][8*b +: 8] = wd[i][8*b +: 8];
          m_known[i][w] = m_known[i][w] | ws[i];
          m_busy[i] = m_e[i] + 1 + ww(i);
        end
      end
      m_e[i]++;
      if (m_e[i] == m_due[i]) begin
        m_rd[i] = m_pd[i];
        m_rm[i] = m_pm[i];
      end
    end
  endtask
  initial begin
    tbl[0] = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h10,        32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h10,        32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 32'h10,        32'h00001200, 4'h2, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 32'h10,        32'h0,        4'h0, 1'b1, 1'b1, 32'hDEAD12EF};
    tbl[5] = '{1'b1, 32'h1010,      32'hCAFE0000, 4'hC, 1'b1, 1'b0, 32'hDEAD12EF};
    tbl[6] = '{1'b1, 32'h13,        32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFE12EF};
    tbl[7] = '{1'b1, 32'h8000_0010, 32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFE12EF};
    tbl[8] = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 1'b0, 32'hCAFE12EF};
    for (int i = 0; i < 2; i++) begin
      av[i] = 0; ad[i] = 0; wd[i] = 0; ws[i] = 0; ck[i] = 1; rs[i] = 1;
    end
    repeat (2) @(negedge clk);
    rs[0] = 0; rs[1] = 0;
    for (int r = 0; r < 9; r++) begin
      drive(0, tbl[r].av, tbl[r].addr, tbl[r].wd, tbl[r].ws, 1'b1, 1'b0);
      chk($sformatf("vec%0d_ready", r), rdy[0], tbl[r].rdy);
      chk($sformatf("vec%0d_rvalid", r), rv[0], tbl[r].rv);
      chk($sformatf("vec%0d_rdata", r), rdt[0], tbl[r].rd);
    end
    // u1: write wait-states with address aliasing, then latency-4 reads
    drive(1, 1, 32'h40, 32'h55, 4'hF, 1, 0);
    chk("ww_t1_ready", rdy[1], 0); chk("ww_t1_rvalid", rv[1], 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("ww_t2_ready", rdy[1], 0); chk("ww_t2_rvalid", rv[1], 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("ww_t3_ready", rdy[1], 1);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 32'h0, 0, 0, 1, 0);
      chk($sformatf("rl_t%0d_ready", k), rdy[1], 0);
      chk($sformatf("rl_t%0d_rvalid", k), rv[1], 0);
    end
    drive(1, 1, 32'h0, 0, 0, 1, 0);
    chk("rl_t4_rvalid", rv[1], 1); chk("rl_t4_rdata", rdt[1], 32'h55); chk("rl_t4_ready", rdy[1], 1);
    drive(1, 1, 32'h0, 0, 0, 1, 0);
    chk("rl2_t1_ready", rdy[1], 0); chk("rl2_t1_rvalid", rv[1], 0);
    for (int k = 2; k <= 3; k++) begin
      drive(1, 0, 0, 0, 0, 1, 0);
      chk($sformatf("rl2_t%0d_rvalid", k), rv[1], 0);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("rl2_t4_rvalid", rv[1], 1); chk("rl2_t4_rdata", rdt[1], 32'h55);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("stall%0d_rvalid", k), rv[1], 1);
      chk($sformatf("stall%0d_rdata", k), rdt[1], 32'h55);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("stall_end_rvalid", rv[1], 0); chk("stall_end_rdata", rdt[1], 32'h55);
    // u1: reset while a read is in flight
    drive(1, 1, 32'h3C, 32'h12345678, 4'hF, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("rst_pre_ready", rdy[1], 1);
    drive(1, 1, 32'h3C, 0, 0, 1, 0);
    chk("rst_t1_ready", rdy[1], 0);
    drive(1, 0, 0, 0, 0, 1, 1);
    chk("rst_t2_ready", rdy[1], 1); chk("rst_t2_rvalid", rv[1], 0); chk("rst_t2_rdata", rdt[1], 0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 0, 0, 1, 0);
      chk($sformatf("rst_quiet%0d_rvalid", k), rv[1], 0);
    end
    drive(1, 1, 32'h3C, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 1, 0);
      chk($sformatf("rst_reread%0d_rvalid", k), rv[1], k == 2);
    end
    chk("rst_reread_rdata", rdt[1], 32'h12345678);
    // randomized traffic on both instances, bytes never written by the model are don't-care
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 1024; w++) m_known[i][w] = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        av[i] = 1'($urandom % 2);
        ad[i] = i == 0 ? ($urandom & 32'hFFFF_F03F) : $urandom;
        wd[i] = $urandom;
        ws[i] = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
        ck[i] = ($urandom % 8) != 0;
        rs[i] = (c == 0) || ($urandom % 300 == 0);
        model(i);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rand_u%0d_c%0d_ready", i, c), rdy[i], m_e[i] >= m_busy[i]);
        chk($sformatf("rand_u%0d_c%0d_rvalid", i, c), rv[i], m_e[i] == m_due[i]);
        chk($sformatf("rand_u%0d_c%0d_rdata", i, c), rdt[i] & m_rm[i], m_rd[i] & m_rm[i]);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
